control_monitor: RTL and testbench

CONTROL_MONITOR -- requirements
Module: control_monitor

---
 rtl/control_monitor_pkg.sv | 26 ++
 rtl/control_monitor_phase_encode.sv | 23 ++
 rtl/control_monitor.sv | 161 ++++++++++++++++
 tb/tb_control_monitor.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/control_monitor_pkg.sv
// Shared types and constants for the control-sequencer phase monitor.
package control_monitor_pkg;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_ONEHOT = 2'b01;
    localparam logic [1:0] ERR_STEP   = 2'b10;
    localparam logic [1:0] ERR_HOLD   = 2'b11;

    localparam int unsigned NUM_PHASES = 6;

    // Successor phase in the cyclic 0..5 sequence.
    function automatic logic [2:0] next_phase(input logic [2:0] p);
        if (p == 3'(NUM_PHASES - 1)) begin
            return 3'd0;
        end else begin
            return p + 3'd1;
        end
    endfunction

endpackage

// File: rtl/control_monitor_phase_encode.sv
// Maps the six phase strobes to a phase index plus an exactly-one-high flag.
module phase_encode (
    input  logic [5:0] strobes_s,
    output logic [2:0] idx_s,
    output logic       legal_s
);

    // Only the six one-hot patterns are legal; everything else reports index 0.
    always_comb begin
        idx_s   = 3'd0;
        legal_s = 1'b1;
        case (strobes_s)
            6'b000001: idx_s = 3'd0;
            6'b000010: idx_s = 3'd1;
            6'b000100: idx_s = 3'd2;
            6'b001000: idx_s = 3'd3;
            6'b010000: idx_s = 3'd4;
            6'b100000: idx_s = 3'd5;
            default:   legal_s = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_monitor.sv
// Watches the S0..S5 phase strobes for one-hot, in-order stepping and bounded
// hold time; latches the first fault until CLR or RESET.
module control_monitor #(
    parameter int unsigned HOLD_MAX = 15,
    parameter int unsigned ROUND_W  = 8
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               CLR,
    input  logic               S0,
    input  logic               S1,
    input  logic               S2,
    input  logic               S3,
    input  logic               S4,
    input  logic               S5,
    output logic [2:0]         PHASE,
    output logic               VALID,
    output logic               SEQ_ERR,
    output logic               ERR_STICKY,
    output logic [1:0]         ERR_CODE,
    output logic [ROUND_W-1:0] ROUNDS
);
    import control_monitor_pkg::*;

    localparam int unsigned HOLD_W = $clog2(HOLD_MAX + 1);

    state_e              state_q, state_d;
    logic [2:0]          phase_q, phase_d;
    logic                valid_q, valid_d;
    logic                seq_err_q, seq_err_d;
    logic                sticky_q, sticky_d;
    logic [1:0]          err_code_q, err_code_d;
    logic [ROUND_W-1:0]  rounds_q, rounds_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;

    logic [2:0]          idx_s;
    logic                legal_s;
    logic                fault_s;
    logic [1:0]          fault_code_s;

    phase_encode u_phase_encode (
        .strobes_s ({S5, S4, S3, S2, S1, S0}),
        .idx_s     (idx_s),
        .legal_s   (legal_s)
    );

    // Next-state and next-output logic; CLR overrides any fault detected this cycle.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        valid_d      = valid_q;
        seq_err_d    = 1'b0;
        sticky_d     = sticky_q;
        err_code_d   = err_code_q;
        rounds_d     = rounds_q;
        hold_d       = hold_q;
        fault_s      = 1'b0;
        fault_code_s = ERR_NONE;

        if (CLR) begin
            state_d    = ST_SYNC;
            phase_d    = 3'd0;
            valid_d    = 1'b0;
            sticky_d   = 1'b0;
            err_code_d = ERR_NONE;
            rounds_d   = '0;
            hold_d     = '0;
        end else begin
            case (state_q)
                ST_SYNC: begin
                    if (legal_s && (idx_s == 3'd0)) begin
                        state_d  = ST_TRACK;
                        phase_d  = 3'd0;
                        valid_d  = 1'b1;
                        hold_d   = '0;
                        rounds_d = '0;
                    end else begin
                        state_d = ST_SYNC;
                    end
                end
                ST_TRACK: begin
                    if (!legal_s) begin
                        fault_s      = 1'b1;
                        fault_code_s = ERR_ONEHOT;
                    end else if (idx_s == phase_q) begin
                        // Reaching HOLD_MAX repeats faults, so the counter never wraps.
                        if (hold_q == HOLD_W'(HOLD_MAX - 1)) begin
                            fault_s      = 1'b1;
                            fault_code_s = ERR_HOLD;
                        end else begin
                            hold_d = hold_q + HOLD_W'(1);
                        end
                    end else if (idx_s == next_phase(phase_q)) begin
                        phase_d = idx_s;
                        hold_d  = '0;
                        if (phase_q == 3'(NUM_PHASES - 1)) begin
                            rounds_d = rounds_q + ROUND_W'(1);
                        end else begin
                            rounds_d = rounds_q;
                        end
                    end else begin
                        fault_s      = 1'b1;
                        fault_code_s = ERR_STEP;
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_SYNC;
                    valid_d = 1'b0;
                end
            endcase

            if (fault_s) begin
                state_d   = ST_FAULT;
                valid_d   = 1'b0;
                seq_err_d = 1'b1;
                sticky_d  = 1'b1;
                if (err_code_q == ERR_NONE) begin
                    err_code_d = fault_code_s;
                end else begin
                    err_code_d = err_code_q;
                end
            end else begin
                seq_err_d = 1'b0;
            end
        end
    end

    // State and output registers; RESET dominates CLR and strobes.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_SYNC;
            phase_q    <= 3'd0;
            valid_q    <= 1'b0;
            seq_err_q  <= 1'b0;
            sticky_q   <= 1'b0;
            err_code_q <= ERR_NONE;
            rounds_q   <= '0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            valid_q    <= valid_d;
            seq_err_q  <= seq_err_d;
            sticky_q   <= sticky_d;
            err_code_q <= err_code_d;
            rounds_q   <= rounds_d;
            hold_q     <= hold_d;
        end
    end

    assign PHASE      = phase_q;
    assign VALID      = valid_q;
    assign SEQ_ERR    = seq_err_q;
    assign ERR_STICKY = sticky_q;
    assign ERR_CODE   = err_code_q;
    assign ROUNDS     = rounds_q;

endmodule

// File: tb/tb_control_monitor.sv
// Directed bench for control_monitor with hand-computed expectations.
module tb_control_monitor;

    logic       clk = 1'b0;
    logic       reset;
    logic       clr;
    logic [5:0] strb;
    logic [2:0] phase;
    logic       valid;
    logic       seq_err;
    logic       sticky;
    logic [1:0] err_code;
    logic [7:0] rounds;

    int n_checks = 0;
    int n_fail   = 0;

    control_monitor #(.HOLD_MAX(15), .ROUND_W(8)) dut (
        .CLK        (clk),
        .RESET      (reset),
        .CLR        (clr),
        .S0         (strb[0]),
        .S1         (strb[1]),
        .S2         (strb[2]),
        .S3         (strb[3]),
        .S4         (strb[4]),
        .S5         (strb[5]),
        .PHASE      (phase),
        .VALID      (valid),
        .SEQ_ERR    (seq_err),
        .ERR_STICKY (sticky),
        .ERR_CODE   (err_code),
        .ROUNDS     (rounds)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one strobe sample around a rising edge; outputs are settled afterwards.
    task automatic step(input logic [5:0] s);
        @(negedge clk);
        strb = s;
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [2:0] ph, input logic v,
                               input logic se, input logic st, input logic [1:0] ec,
                               input logic [7:0] rn);
        check_eq({tag, ".phase"},   32'(phase),    32'(ph));
        check_eq({tag, ".valid"},   32'(valid),    32'(v));
        check_eq({tag, ".seq_err"}, 32'(seq_err),  32'(se));
        check_eq({tag, ".sticky"},  32'(sticky),   32'(st));
        check_eq({tag, ".code"},    32'(err_code), 32'(ec));
        check_eq({tag, ".rounds"},  32'(rounds),   32'(rn));
    endtask

    function automatic logic [5:0] oh(input int p);
        return 6'(1 << p);
    endfunction

    initial begin
        reset = 1'b1;
        clr   = 1'b0;
        strb  = 6'b000000;
        step(6'b000000);
        step(6'b000000);
        check_state("reset", 3'd0, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0);
        reset = 1'b0;

        // SYNC ignores anything but a clean S0
        step(oh(1));
        check_state("sync_s1", 3'd0, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0);
        step(6'b000011);
        check_state("sync_multi", 3'd0, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0);

        // Two full rounds
        step(oh(0));
        check_state("lock", 3'd0, 1'b1, 1'b0, 1'b0, 2'b00, 8'd0);
        for (int p = 1; p < 6; p++) begin
            step(oh(p));
            check_eq("round1.phase", 32'(phase), 32'(p));
        end
        step(oh(0));
        check_state("wrap1", 3'd0, 1'b1, 1'b0, 1'b0, 2'b00, 8'd1);
        for (int p = 1; p < 6; p++) begin
            step(oh(p));
            check_eq("round2.phase", 32'(phase), 32'(p));
        end
        check_state("round2_end", 3'd5, 1'b1, 1'b0, 1'b0, 2'b00, 8'd1);

        // Multiple strobes at PHASE=2
        step(oh(0));
        step(oh(1));
        step(oh(2));
        check_state("at2", 3'd2, 1'b1, 1'b0, 1'b0, 2'b00, 8'd2);
        step(6'b001100);
        check_state("onehot_fault", 3'd2, 1'b0, 1'b1, 1'b1, 2'b01, 8'd2);
        step(oh(3));
        check_state("onehot_after", 3'd2, 1'b0, 1'b0, 1'b1, 2'b01, 8'd2);
        step(6'b000000);
        check_state("fault_persist", 3'd2, 1'b0, 1'b0, 1'b1, 2'b01, 8'd2);

        // CLR exits FAULT, S0 relocks
        clr = 1'b1;
        step(6'b000000);
        clr = 1'b0;
        check_state("clr", 3'd0, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0);
        step(oh(3));
        check_eq("clr_sync.valid", 32'(valid), 32'd0);
        step(oh(0));
        check_state("relock", 3'd0, 1'b1, 1'b0, 1'b0, 2'b00, 8'd0);

        // Illegal step 1 -> 4, then only one fault recorded
        step(oh(1));
        step(oh(4));
        check_state("step_fault", 3'd1, 1'b0, 1'b1, 1'b1, 2'b10, 8'd0);
        for (int p = 3; p < 6; p++) begin
            step(oh(p));
            check_eq("step_after.seq_err", 32'(seq_err), 32'd0);
            check_eq("step_after.code", 32'(err_code), 32'd2);
        end

        // Hold boundary: 14 repeats allowed, 15th repeat faults
        clr = 1'b1;
        step(6'b000000);
        clr = 1'b0;
        for (int p = 0; p < 4; p++) step(oh(p));
        for (int i = 0; i < 14; i++) step(oh(3));
        check_state("hold3_14", 3'd3, 1'b1, 1'b0, 1'b0, 2'b00, 8'd0);
        step(oh(4));
        check_state("hold_step4", 3'd4, 1'b1, 1'b0, 1'b0, 2'b00, 8'd0);
        for (int i = 0; i < 14; i++) step(oh(4));
        check_state("hold4_14", 3'd4, 1'b1, 1'b0, 1'b0, 2'b00, 8'd0);
        step(oh(4));
        check_state("hold4_15", 3'd4, 1'b0, 1'b1, 1'b1, 2'b11, 8'd0);

        // CLR coincident with a fault condition wins
        clr = 1'b1;
        step(6'b000000);
        clr = 1'b0;
        step(oh(0));
        clr = 1'b1;
        step(6'b000011);
        clr = 1'b0;
        check_state("clr_wins", 3'd0, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0);

        // ROUNDS wraps modulo 256
        step(oh(0));
        for (int r = 0; r < 255; r++) begin
            for (int p = 1; p < 6; p++) step(oh(p));
            step(oh(0));
        end
        check_state("rounds255", 3'd0, 1'b1, 1'b0, 1'b0, 2'b00, 8'd255);
        for (int p = 1; p < 6; p++) step(oh(p));
        step(oh(0));
        check_state("rounds_wrap", 3'd0, 1'b1, 1'b0, 1'b0, 2'b00, 8'd0);

        // RESET + CLR + illegal strobes mid-TRACK
        step(oh(1));
        reset = 1'b1;
        clr   = 1'b1;
        step(6'b101010);
        reset = 1'b0;
        clr   = 1'b0;
        check_state("reset_mid", 3'd0, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0);
        step(oh(1));
        check_eq("post_reset_s1.valid", 32'(valid), 32'd0);
        step(oh(0));
        check_eq("post_reset_s0.valid", 32'(valid), 32'd1);

        // RESET while in FAULT
        step(oh(2));
        check_eq("pre_reset_fault.sticky", 32'(sticky), 32'd1);
        reset = 1'b1;
        step(6'b000000);
        reset = 1'b0;
        check_state("reset_fault", 3'd0, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
